// File: rtl/fetch_prefetch_queue_if.sv
// Handshake bundle between fetch, the I-side memory port, redirect source and decode.
interface fetch_prefetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            mem_read;
  logic [XLEN-1:0] mem_addr;
  logic            mem_resp;
  logic [XLEN-1:0] mem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    input  redirect_valid, redirect_pc, mem_resp, mem_rdata, out_ready,
    output mem_read, mem_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_resp, mem_rdata, out_ready,
    input  mem_read, mem_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Sequential-PC fetch unit with one outstanding read and a DEPTH-entry {pc, instr} queue.
module fetch_prefetch_queue #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fetch_prefetch_queue_if.master  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;
  localparam logic [1:0] ISSUE  = BUSY;

  logic [1:0]      state, state_d;
  logic [XLEN-1:0] fetch_pc, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic            push, pop;
  logic [CNT_W:0]  occ_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_aligned;

  assign push             = (state == BUSY) && bus.mem_resp && !bus.redirect_valid;
  assign pop              = (count != '0) && bus.out_ready && !bus.redirect_valid;
  assign occ_next         = {1'b0, count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign pc_plus4         = fetch_pc + XLEN'(4);
  assign redirect_aligned = bus.redirect_pc & ~XLEN'(3);

  assign bus.mem_read  = (state != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = pc_mem[rd_ptr];
  assign bus.out_instr = instr_mem[rd_ptr];

  // addr_q is separate from fetch_pc so SQUASH can hold the abandoned address
  // on the bus while fetch_pc already carries the redirect target.
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    addr_d     = addr_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      case (state)
        IDLE: begin
          state_d = BUSY;
          addr_d  = redirect_aligned;
        end
        BUSY: begin
          if (bus.mem_resp) begin
            state_d = BUSY;
            addr_d  = redirect_aligned;
          end else begin
            state_d = SQUASH;
          end
        end
        default: begin
          if (bus.mem_resp) begin
            state_d = BUSY;
            addr_d  = redirect_aligned;
          end
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (occ_next < (CNT_W+1)'(DEPTH)) begin
            state_d = BUSY;
            addr_d  = fetch_pc;
          end
        end
        BUSY: begin
          if (bus.mem_resp) begin
            fetch_pc_d = pc_plus4;
            if (occ_next < (CNT_W+1)'(DEPTH)) begin
              addr_d = pc_plus4;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          if (bus.mem_resp) begin
            state_d = BUSY;
            addr_d  = fetch_pc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ISSUE;
      fetch_pc <= XLEN'(RESET_PC);
      addr_q   <= XLEN'(RESET_PC);
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      addr_q   <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect_valid) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= occ_next[CNT_W-1:0];
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: streaming, back-pressure, redirect, wrap, reset.
module tb_fetch_prefetch_queue;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fetch_prefetch_queue_if #(.XLEN(32)) bus ();

  fetch_prefetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0060)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp_on(input logic [31:0] a);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = instr_of(a);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_resp       = 1'b0;
    bus.mem_rdata      = '0;
    bus.out_ready      = 1'b0;

    #12;
    chk("rst_mem_read", 32'(bus.mem_read), 32'd1);
    chk("rst_mem_addr", bus.mem_addr, 32'h60);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    rst_n = 1'b1;
    tick();

    // Back-to-back streaming with decode always ready
    bus.out_ready = 1'b1;
    resp_on(32'h60);
    tick();
    chk("s1_head_pc", bus.out_pc, 32'h60);
    chk("s1_head_instr", bus.out_instr, instr_of(32'h60));
    chk("s1_addr", bus.mem_addr, 32'h64);
    chk("s1_read", 32'(bus.mem_read), 32'd1);
    resp_on(32'h64);
    tick();
    chk("s2_head_pc", bus.out_pc, 32'h64);
    chk("s2_valid", 32'(bus.out_valid), 32'd1);
    chk("s2_addr", bus.mem_addr, 32'h68);
    resp_on(32'h68);
    tick();
    chk("s3_head_instr", bus.out_instr, instr_of(32'h68));
    chk("s3_addr", bus.mem_addr, 32'h6C);
    bus.mem_resp = 1'b0;
    tick();
    chk("s4_drained", 32'(bus.out_valid), 32'd0);
    chk("s4_addr_hold", bus.mem_addr, 32'h6C);

    // Back-pressure: fill four entries, fetch must stop
    bus.out_ready = 1'b0;
    resp_on(32'h6C); tick();
    chk("f1_addr", bus.mem_addr, 32'h70);
    resp_on(32'h70); tick();
    resp_on(32'h74); tick();
    chk("f3_addr", bus.mem_addr, 32'h78);
    chk("f3_read", 32'(bus.mem_read), 32'd1);
    resp_on(32'h78); tick();
    bus.mem_resp = 1'b0;
    chk("full_read_low", 32'(bus.mem_read), 32'd0);
    chk("full_head_pc", bus.out_pc, 32'h6C);
    tick();
    chk("full_still_idle", 32'(bus.mem_read), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("refill_read", 32'(bus.mem_read), 32'd1);
    chk("refill_addr", bus.mem_addr, 32'h7C);
    chk("refill_head", bus.out_pc, 32'h70);

    // Push and pop on the same edge with three entries held
    bus.out_ready = 1'b1;
    resp_on(32'h7C);
    tick();
    bus.mem_resp = 1'b0;
    chk("pp_head", bus.out_pc, 32'h74);
    chk("pp_addr", bus.mem_addr, 32'h80);
    tick();
    chk("pp_order1", bus.out_pc, 32'h78);
    tick();
    chk("pp_order2", bus.out_pc, 32'h7C);
    chk("pp_order2_instr", bus.out_instr, instr_of(32'h7C));
    tick();
    chk("pp_empty", 32'(bus.out_valid), 32'd0);

    // Redirect while a read is outstanding: old response must be dropped
    bus.out_ready = 1'b0;
    resp_on(32'h80);
    tick();
    bus.mem_resp = 1'b0;
    chk("rd_pre_head", bus.out_pc, 32'h80);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    chk("sq_flush", 32'(bus.out_valid), 32'd0);
    chk("sq_addr_hold", bus.mem_addr, 32'h84);
    chk("sq_read", 32'(bus.mem_read), 32'd1);
    tick();
    tick();
    chk("sq_addr_hold2", bus.mem_addr, 32'h84);
    resp_on(32'h84);
    tick();
    bus.mem_resp = 1'b0;
    chk("sq_dropped", 32'(bus.out_valid), 32'd0);
    chk("sq_new_addr", bus.mem_addr, 32'h200);
    tick();
    chk("sq_still_empty", 32'(bus.out_valid), 32'd0);
    resp_on(32'h200);
    tick();
    bus.mem_resp = 1'b0;
    chk("rd_head", bus.out_pc, 32'h200);
    chk("rd_next_addr", bus.mem_addr, 32'h204);

    // Redirect coinciding with a response and a pop; target low bits cleared
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h401;
    resp_on(32'h204);
    tick();
    bus.redirect_valid = 1'b0;
    bus.mem_resp       = 1'b0;
    chk("rc_empty", 32'(bus.out_valid), 32'd0);
    chk("rc_addr", bus.mem_addr, 32'h400);
    tick();
    chk("rc_no_push", 32'(bus.out_valid), 32'd0);
    resp_on(32'h400);
    tick();
    bus.mem_resp = 1'b0;
    chk("rc_head_pc", bus.out_pc, 32'h400);
    chk("rc_head_instr", bus.out_instr, instr_of(32'h400));

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    resp_on(32'h404);
    tick();
    bus.redirect_valid = 1'b0;
    chk("wr_addr", bus.mem_addr, 32'hFFFF_FFFC);
    resp_on(32'hFFFF_FFFC);
    tick();
    chk("wr_head", bus.out_pc, 32'hFFFF_FFFC);
    chk("wr_next_addr", bus.mem_addr, 32'h0000_0000);
    resp_on(32'h0);
    tick();
    chk("wr_head0", bus.out_pc, 32'h0);

    // Asynchronous reset in the middle of a burst
    resp_on(32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_read", 32'(bus.mem_read), 32'd1);
    chk("ar_addr", bus.mem_addr, 32'h60);
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_pc", bus.out_pc, 32'h0);
    chk("ar_instr", bus.out_instr, 32'h0);
    bus.mem_resp = 1'b0;
    tick();
    rst_n = 1'b1;
    resp_on(32'h60);
    tick();
    bus.mem_resp = 1'b0;
    chk("post_rst_head", bus.out_pc, 32'h60);
    chk("post_rst_addr", bus.mem_addr, 32'h64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
